snn_output_store: RTL and testbench

- Responder to the core controller's output-store phase: owns the output counter that the controller drives through output_cntr_rst/output_cntr_en, and returns outputs_done.
- Walks the output-neuron spike counters one index per enabled cycle, captures each count into a local result register file, and tracks the winning neuron (argmax).
- Exposes the results to the host through a registered read port.

---
 rtl/snn_output_store_if.sv | 76 +++++++
 rtl/snn_output_store.sv | 183 ++++++++++++++++++
 tb/tb_snn_output_store.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_output_store_if.sv
// -----------------------------------------------------------------------------
// snn_output_store_if
//
// Bundles every non-clock/reset signal of snn_output_store: the controller
// handshake for the output-store phase, the spike-counter select/return bus,
// the accumulate-clear strobe, the host read port and the result outputs.
//
// Parameters:
//   NUM_OUTPUTS  number of output neurons (>= 2)
//   COUNT_WIDTH  width of one spike count
//   IDX_WIDTH    index width, $clog2(NUM_OUTPUTS); derived, leave at default
//
// Modports:
//   master  controller / host / counter-array side (drives the requests)
//   slave   snn_output_store side
//
// Signals:
//   output_cntr_rst  m->s  clear index/flags, start a new store pass
//   output_cntr_en   m->s  store one count this cycle
//   outputs_done     s->m  all NUM_OUTPUTS counts stored
//   spike_count_sel  s->m  current index, selects the neuron counter
//   spike_count_in   m->s  count of the selected neuron, same cycle
//   accum_clr        m->s  clear stored results (accumulate build only)
//   host_rd_addr     m->s  host read index
//   host_rd_data     s->m  registered read data, 1-cycle latency
//   result_valid     s->m  results and argmax are complete and stable
//   max_idx          s->m  index of the largest stored count
//   max_count        s->m  largest stored count
// -----------------------------------------------------------------------------
interface snn_output_store_if #(
  parameter int NUM_OUTPUTS = 10,
  parameter int COUNT_WIDTH = 16,
  parameter int IDX_WIDTH   = $clog2(NUM_OUTPUTS)
);

  logic                   output_cntr_rst;
  logic                   output_cntr_en;
  logic                   outputs_done;
  logic [IDX_WIDTH-1:0]   spike_count_sel;
  logic [COUNT_WIDTH-1:0] spike_count_in;
  logic                   accum_clr;
  logic [IDX_WIDTH-1:0]   host_rd_addr;
  logic [COUNT_WIDTH-1:0] host_rd_data;
  logic                   result_valid;
  logic [IDX_WIDTH-1:0]   max_idx;
  logic [COUNT_WIDTH-1:0] max_count;

  modport master (
    output output_cntr_rst,
    output output_cntr_en,
    output spike_count_in,
    output accum_clr,
    output host_rd_addr,
    input  outputs_done,
    input  spike_count_sel,
    input  host_rd_data,
    input  result_valid,
    input  max_idx,
    input  max_count
  );

  modport slave (
    input  output_cntr_rst,
    input  output_cntr_en,
    input  spike_count_in,
    input  accum_clr,
    input  host_rd_addr,
    output outputs_done,
    output spike_count_sel,
    output host_rd_data,
    output result_valid,
    output max_idx,
    output max_count
  );

endinterface : snn_output_store_if

// File: rtl/snn_output_store.sv
// -----------------------------------------------------------------------------
// snn_output_store
//
// Output-store responder for the SNN core controller. During a store pass the
// controller pulses output_cntr_rst once and then raises output_cntr_en; each
// enabled cycle the block presents its index on spike_count_sel, captures the
// returned spike count into a local result register file and updates the
// running argmax. After NUM_OUTPUTS writes it enters COMPLETE and raises
// outputs_done / result_valid. The host reads results through a registered
// port with one cycle of latency.
//
// Optional feature (macro SNN_OUTPUT_ACCUM_EN):
//   defined   - each write adds the count to the stored entry, saturating at
//               2^COUNT_WIDTH-1; argmax uses the accumulated value; accum_clr
//               zeroes all entries and the argmax (clear beats a write).
//   undefined - each write overwrites the entry; accum_clr is ignored.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset (clears everything incl. results)
//   bus    snn_output_store_if.slave, see the interface header for signals
// -----------------------------------------------------------------------------
module snn_output_store #(
  parameter int NUM_OUTPUTS = 10,
  parameter int COUNT_WIDTH = 16,
  parameter int IDX_WIDTH   = $clog2(NUM_OUTPUTS)
) (
  input  logic                clk,
  input  logic                rst_n,
  snn_output_store_if.slave   bus
);

  localparam logic [IDX_WIDTH-1:0]   LAST_IDX  = IDX_WIDTH'(NUM_OUTPUTS - 1);
  localparam logic [IDX_WIDTH:0]     NUM_OUT_W = (IDX_WIDTH + 1)'(NUM_OUTPUTS);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic {
    ST_STORE    = 1'b0,
    ST_COMPLETE = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                 state_q,     state_d;
  logic [IDX_WIDTH-1:0]   idx_q,       idx_d;
  logic [IDX_WIDTH-1:0]   max_idx_q,   max_idx_d;
  logic [COUNT_WIDTH-1:0] max_count_q, max_count_d;
  logic [COUNT_WIDTH-1:0] rd_data_q,   rd_data_d;
  logic [COUNT_WIDTH-1:0] mem_q [NUM_OUTPUTS];

  // Write-port controls for the result register file.
  logic                   mem_we;
  logic                   mem_clr;
  logic [COUNT_WIDTH-1:0] wr_val;

  // ---------------------------------------------------------------------------
  // Value written for the current index
  // ---------------------------------------------------------------------------
`ifdef SNN_OUTPUT_ACCUM_EN
  logic [COUNT_WIDTH:0] acc_sum;

  // One extra bit catches the carry; a carry means saturate.
  assign acc_sum = {1'b0, mem_q[idx_q]} + {1'b0, bus.spike_count_in};
  assign wr_val  = acc_sum[COUNT_WIDTH] ? COUNT_MAX : acc_sum[COUNT_WIDTH-1:0];
  assign mem_clr = bus.accum_clr;
`else
  logic unused_accum_clr;
  logic [COUNT_WIDTH-1:0] unused_count_max;

  assign wr_val           = bus.spike_count_in;
  assign mem_clr          = 1'b0;
  assign unused_accum_clr = bus.accum_clr;
  assign unused_count_max = COUNT_MAX;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    max_idx_d   = max_idx_q;
    max_count_d = max_count_q;
    mem_we      = 1'b0;

    if (bus.output_cntr_rst) begin
      // Start of a new pass; stored results are kept so the host can still
      // read the previous pass until entries get overwritten.
      state_d     = ST_STORE;
      idx_d       = '0;
      max_idx_d   = '0;
      max_count_d = '0;
    end else if (mem_clr) begin
      // Accumulate clear: wipes the argmax too, index and done are untouched;
      // any write in the same cycle is dropped.
      max_idx_d   = '0;
      max_count_d = '0;
    end else if (bus.output_cntr_en) begin
      unique case (state_q)
        ST_STORE: begin
          mem_we = 1'b1;
          // Strict compare keeps the lowest index on ties; index 0 always
          // seeds the argmax so a pass of all-zero counts still reports 0.
          if ((wr_val > max_count_q) || (idx_q == '0)) begin
            max_count_d = wr_val;
            max_idx_d   = idx_q;
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_COMPLETE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_COMPLETE: begin
          // Trailing enable from the controller: nothing changes.
        end
        default: begin
          state_d = ST_STORE;
        end
      endcase
    end
  end

  // Host read: out-of-range addresses return zero. Reading mem_q (not the
  // value being written) gives the old entry on a same-cycle collision.
  always_comb begin
    rd_data_d = '0;
    if ({1'b0, bus.host_rd_addr} < NUM_OUT_W) begin
      rd_data_d = mem_q[bus.host_rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its next value from the same pre-edge snapshot.
    if (!rst_n) begin
      state_q     <= ST_STORE;
      idx_q       <= '0;
      max_idx_q   <= '0;
      max_count_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      max_idx_q   <= max_idx_d;
      max_count_q <= max_count_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Result register file.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this storage is reset on purpose: results must read back as zero
    // after reset and an aborted pass. That keeps it in flops, not a RAM macro.
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_clr) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx_q] <= wr_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.outputs_done    = (state_q == ST_COMPLETE);
  assign bus.result_valid    = (state_q == ST_COMPLETE);
  assign bus.spike_count_sel = idx_q;
  assign bus.host_rd_data    = rd_data_q;
  assign bus.max_idx         = max_idx_q;
  assign bus.max_count       = max_count_q;

endmodule : snn_output_store

// File: tb/tb_snn_output_store.sv
// -----------------------------------------------------------------------------
// tb_snn_output_store
//
// Self-checking bench for snn_output_store. A 4-output, 8-bit instance takes
// a table of per-cycle vectors (basic pass, trailing enables, restart with
// overwrite/read collision) followed by hand-written sequences for the async
// reset, stall/abort and accumulate behaviour. A 5-output instance gives a
// 3-bit index so out-of-range host reads can be exercised.
// Expectations depend on SNN_OUTPUT_ACCUM_EN where the feature changes them.
// -----------------------------------------------------------------------------
module tb_snn_output_store;

`ifdef SNN_OUTPUT_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  snn_output_store_if #(.NUM_OUTPUTS(4), .COUNT_WIDTH(8)) bus4 ();
  snn_output_store_if #(.NUM_OUTPUTS(5), .COUNT_WIDTH(8)) bus5 ();

  snn_output_store #(.NUM_OUTPUTS(4), .COUNT_WIDTH(8)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  snn_output_store #(.NUM_OUTPUTS(5), .COUNT_WIDTH(8)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the bench uses only fixed cycle counts, this is a safety net.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs are changed 1 time unit after the edge; outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected state after a vector's clock edge.
  typedef struct packed {
    logic       cr;
    logic       en;
    logic [7:0] cnt;
    logic [1:0] addr;
    logic       done;
    logic [1:0] sel;
    logic [1:0] mi;
    logic [7:0] mc;
    logic [7:0] rd;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic cr, logic en, logic [7:0] cnt,
                              logic [1:0] addr, logic done, logic [1:0] sel,
                              logic [1:0] mi, logic [7:0] mc, logic [7:0] rd);
    vec_t v;
    v.cr = cr; v.en = en; v.cnt = cnt; v.addr = addr;
    v.done = done; v.sel = sel; v.mi = mi; v.mc = mc; v.rd = rd;
    return v;
  endfunction

  task automatic drive4(logic cr, logic en, logic [7:0] cnt, logic clr,
                        logic [1:0] addr);
    bus4.output_cntr_rst = cr;
    bus4.output_cntr_en  = en;
    bus4.spike_count_in  = cnt;
    bus4.accum_clr       = clr;
    bus4.host_rd_addr    = addr;
  endtask

  task automatic drive5(logic cr, logic en, logic [7:0] cnt,
                        logic [2:0] addr);
    bus5.output_cntr_rst = cr;
    bus5.output_cntr_en  = en;
    bus5.spike_count_in  = cnt;
    bus5.accum_clr       = 1'b0;
    bus5.host_rd_addr    = addr;
  endtask

  initial begin
    logic [7:0] p1 [4];
    logic [7:0] p2 [4];
    logic [7:0] c5 [5];

    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    drive4(1'b0, 1'b0, 8'd0, 1'b0, 2'd0);
    drive5(1'b0, 1'b0, 8'd0, 3'd0);

    // cr en  cnt  addr done sel mi  mc   rd
    // Basic pass 3,7,2,7: tie on 7 keeps index 1; entry 3 read as old 0.
    vecs[0]  = mk(1, 0, 8'd0,  2'd0, 0, 2'd0, 2'd0, 8'd0, 8'd0);
    vecs[1]  = mk(0, 1, 8'd3,  2'd0, 0, 2'd1, 2'd0, 8'd3, 8'd0);
    vecs[2]  = mk(0, 1, 8'd7,  2'd0, 0, 2'd2, 2'd1, 8'd7, 8'd3);
    vecs[3]  = mk(0, 1, 8'd2,  2'd1, 0, 2'd3, 2'd1, 8'd7, 8'd7);
    vecs[4]  = mk(0, 1, 8'd7,  2'd3, 1, 2'd3, 2'd1, 8'd7, 8'd0);
    vecs[5]  = mk(0, 0, 8'd0,  2'd2, 1, 2'd3, 2'd1, 8'd7, 8'd2);
    // Trailing enables with count 99: nothing may change.
    vecs[6]  = mk(0, 1, 8'd99, 2'd0, 1, 2'd3, 2'd1, 8'd7, 8'd3);
    vecs[7]  = mk(0, 1, 8'd99, 2'd1, 1, 2'd3, 2'd1, 8'd7, 8'd7);
    vecs[8]  = mk(0, 1, 8'd99, 2'd3, 1, 2'd3, 2'd1, 8'd7, 8'd7);
    // Restart with enable also high: rst wins, entries are kept.
    vecs[9]  = mk(1, 1, 8'd99, 2'd2, 0, 2'd0, 2'd0, 8'd0, 8'd2);
    // Second pass 1,1,0,9 on top of {3,7,2,7}; entry 3 written with 9 while
    // being read returns the old 7.
    vecs[10] = mk(0, 1, 8'd1,  2'd0, 0, 2'd1, 2'd0, ACC ? 8'd4 : 8'd1, 8'd3);
    vecs[11] = mk(0, 1, 8'd1,  2'd1, 0, 2'd2, ACC ? 2'd1 : 2'd0,
                  ACC ? 8'd8 : 8'd1, 8'd7);
    vecs[12] = mk(0, 1, 8'd0,  2'd2, 0, 2'd3, ACC ? 2'd1 : 2'd0,
                  ACC ? 8'd8 : 8'd1, 8'd2);
    vecs[13] = mk(0, 1, 8'd9,  2'd3, 1, 2'd3, 2'd3,
                  ACC ? 8'd16 : 8'd9, 8'd7);
    vecs[14] = mk(0, 0, 8'd0,  2'd3, 1, 2'd3, 2'd3,
                  ACC ? 8'd16 : 8'd9, ACC ? 8'd16 : 8'd9);
    vecs[15] = mk(0, 0, 8'd0,  2'd2, 1, 2'd3, 2'd3,
                  ACC ? 8'd16 : 8'd9, ACC ? 8'd2 : 8'd0);

    // ---- Async reset before any clock edge ----
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_done",    32'(bus4.outputs_done),    32'd0);
    check("rst_valid",   32'(bus4.result_valid),    32'd0);
    check("rst_sel",     32'(bus4.spike_count_sel), 32'd0);
    check("rst_max_idx", 32'(bus4.max_idx),         32'd0);
    check("rst_max_cnt", 32'(bus4.max_count),       32'd0);
    check("rst_rd_data", 32'(bus4.host_rd_data),    32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ---- Table-driven vectors ----
    for (int i = 0; i < NVEC; i++) begin
      drive4(vecs[i].cr, vecs[i].en, vecs[i].cnt, 1'b0, vecs[i].addr);
      tick();
      check($sformatf("v%0d_done", i),  32'(bus4.outputs_done),    32'(vecs[i].done));
      check($sformatf("v%0d_valid", i), 32'(bus4.result_valid),    32'(vecs[i].done));
      check($sformatf("v%0d_sel", i),   32'(bus4.spike_count_sel), 32'(vecs[i].sel));
      check($sformatf("v%0d_maxi", i),  32'(bus4.max_idx),         32'(vecs[i].mi));
      check($sformatf("v%0d_maxc", i),  32'(bus4.max_count),       32'(vecs[i].mc));
      check($sformatf("v%0d_rd", i),    32'(bus4.host_rd_data),    32'(vecs[i].rd));
    end

    // ---- Stall then async abort mid-cycle ----
    drive4(1'b1, 1'b0, 8'd0, 1'b0, 2'd0);
    tick();
    drive4(1'b0, 1'b1, 8'd5, 1'b0, 2'd0);
    tick();
    drive4(1'b0, 1'b1, 8'd6, 1'b0, 2'd0);
    tick();
    drive4(1'b0, 1'b0, 8'd77, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_sel", i),  32'(bus4.spike_count_sel), 32'd2);
      check($sformatf("stall%0d_done", i), 32'(bus4.outputs_done),    32'd0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_sel",   32'(bus4.spike_count_sel), 32'd0);
    check("abort_valid", 32'(bus4.result_valid),    32'd0);
    check("abort_maxc",  32'(bus4.max_count),       32'd0);
    check("abort_rd",    32'(bus4.host_rd_data),    32'd0);
    #1;
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      drive4(1'b0, 1'b0, 8'd0, 1'b0, 2'(a));
      tick();
      check($sformatf("abort_mem%0d", a), 32'(bus4.host_rd_data), 32'd0);
    end

    // ---- Two passes: accumulate/saturate vs overwrite, then accum_clr ----
    p1[0] = 8'd200; p1[1] = 8'd10; p1[2] = 8'd0; p1[3] = 8'd0;
    p2[0] = 8'd100; p2[1] = 8'd10; p2[2] = 8'd0; p2[3] = 8'd0;
    drive4(1'b1, 1'b0, 8'd0, 1'b0, 2'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive4(1'b0, 1'b1, p1[i], 1'b0, 2'd0);
      tick();
    end
    drive4(1'b1, 1'b0, 8'd0, 1'b0, 2'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive4(1'b0, 1'b1, p2[i], 1'b0, 2'd0);
      tick();
    end
    drive4(1'b0, 1'b0, 8'd0, 1'b0, 2'd0);
    tick();
    check("acc_done", 32'(bus4.outputs_done), 32'd1);
    check("acc_maxi", 32'(bus4.max_idx),      32'd0);
    check("acc_maxc", 32'(bus4.max_count),    ACC ? 32'd255 : 32'd100);
    check("acc_mem0", 32'(bus4.host_rd_data), ACC ? 32'd255 : 32'd100);
    drive4(1'b0, 1'b0, 8'd0, 1'b0, 2'd1);
    tick();
    check("acc_mem1", 32'(bus4.host_rd_data), ACC ? 32'd20 : 32'd10);
    drive4(1'b0, 1'b0, 8'd0, 1'b1, 2'd0);
    tick();
    drive4(1'b0, 1'b0, 8'd0, 1'b0, 2'd0);
    tick();
    check("clr_mem0", 32'(bus4.host_rd_data),    ACC ? 32'd0 : 32'd100);
    check("clr_maxc", 32'(bus4.max_count),       ACC ? 32'd0 : 32'd100);
    check("clr_maxi", 32'(bus4.max_idx),         32'd0);
    check("clr_done", 32'(bus4.outputs_done),    32'd1);
    check("clr_sel",  32'(bus4.spike_count_sel), 32'd3);

    // ---- 5-output instance: done timing and out-of-range reads ----
    c5[0] = 8'd4; c5[1] = 8'd9; c5[2] = 8'd9; c5[3] = 8'd1; c5[4] = 8'd12;
    drive5(1'b1, 1'b0, 8'd0, 3'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive5(1'b0, 1'b1, c5[i], 3'd0);
      tick();
      check($sformatf("n5_w%0d_done", i), 32'(bus5.outputs_done), (i == 4) ? 32'd1 : 32'd0);
      if (i == 3) begin
        check("n5_tie_maxi", 32'(bus5.max_idx), 32'd1);
      end
    end
    check("n5_maxi", 32'(bus5.max_idx),   32'd4);
    check("n5_maxc", 32'(bus5.max_count), 32'd12);
    drive5(1'b0, 1'b0, 8'd0, 3'd4);
    tick();
    check("n5_rd4", 32'(bus5.host_rd_data), 32'd12);
    drive5(1'b0, 1'b0, 8'd0, 3'd5);
    tick();
    check("n5_rd5", 32'(bus5.host_rd_data), 32'd0);
    drive5(1'b0, 1'b0, 8'd0, 3'd1);
    tick();
    check("n5_rd1", 32'(bus5.host_rd_data), 32'd9);
    drive5(1'b0, 1'b0, 8'd0, 3'd7);
    tick();
    check("n5_rd7", 32'(bus5.host_rd_data), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_snn_output_store
